booth_mult_core: RTL and testbench



---
 rtl/booth_mult_core_pkg.sv | 18 +
 rtl/booth_mult_core_if.sv | 24 ++
 rtl/booth_mult_core_step.sv | 30 +++
 rtl/booth_mult_core.sv | 98 +++++++++
 tb/tb_booth_mult_core.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/booth_mult_core_pkg.sv
// Shared constants, FSM state type and counter sizing for the Booth multiplier.
package booth_pkg;

  localparam int unsigned N_DEF  = 5;
  localparam int unsigned RW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int unsigned CNT_W_DEF = $clog2(N_DEF + 1);

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_mult_core_if.sv
// Request/result bundle of the Booth multiplier; done/busy exist only with BOOTH_DONE_EN.
interface booth_mult_core_if #(
  parameter int unsigned N  = booth_pkg::N_DEF,
  parameter int unsigned RW = booth_pkg::RW_DEF
);

  logic          start;
  logic [N-1:0]  M;
  logic [N-1:0]  Q;
  logic [RW-1:0] result;
`ifdef BOOTH_DONE_EN
  logic          done;
  logic          busy;

  modport master (output start, output M, output Q,
                  input result, input done, input busy);
  modport slave  (input start, input M, input Q,
                  output result, output done, output busy);
`else
  modport master (output start, output M, output Q, input result);
  modport slave  (input start, input M, input Q, output result);
`endif

endinterface

// File: rtl/booth_mult_core_step.sv
// One radix-2 Booth iteration: conditional add/subtract of Mr, then arithmetic shift of {A,Qr,q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] qr_i,
  input  logic         q1_i,
  input  logic [N:0]   mr_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] qr_o,
  output logic         q1_o
);

  logic [N:0] sum;

  always_comb begin
    sum = a_i;
    case ({qr_i[0], q1_i})
      2'b01:   sum = a_i + mr_i;
      2'b10:   sum = a_i - mr_i;
      default: sum = a_i;
    endcase
    a_o  = {sum[N], sum[N:1]};
    qr_o = {sum[0], qr_i[N-1:1]};
    q1_o = qr_i[0];
  end

endmodule

// File: rtl/booth_mult_core.sv
// Sequential signed Booth multiplier: N iterations per start, truncated product on result.
// Optional BOOTH_DONE_EN adds registered done (completion pulse) and busy outputs.
module booth_mult_core
  import booth_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  booth_mult_core_if.slave bus
);

  localparam int unsigned CW = cnt_width(N);

  state_t        state_q;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  qr_q, qr_d;
  logic          q1_q, q1_d;
  logic [N:0]    mr_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] result_q;
  logic [2*N:0]  prod_d;
`ifdef BOOTH_DONE_EN
  logic          done_q;
  logic          busy_q;
`endif

  booth_step #(.N(N)) u_step (
    .a_i  (a_q),
    .qr_i (qr_q),
    .q1_i (q1_q),
    .mr_i (mr_q),
    .a_o  (a_d),
    .qr_o (qr_d),
    .q1_o (q1_d)
  );

  // The result is taken from the step outputs so it lands on the last iteration edge.
  assign prod_d = {a_d, qr_d};

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      qr_q     <= '0;
      q1_q     <= 1'b0;
      mr_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef BOOTH_DONE_EN
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`endif
    end else begin
`ifdef BOOTH_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= '0;
            qr_q    <= bus.Q;
            q1_q    <= 1'b0;
            mr_q    <= {bus.M[N-1], bus.M};
            cnt_q   <= '0;
            state_q <= CALC;
`ifdef BOOTH_DONE_EN
            busy_q  <= 1'b1;
`endif
          end
        end
        CALC: begin
          a_q   <= a_d;
          qr_q  <= qr_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            result_q <= prod_d[RW-1:0];
            state_q  <= IDLE;
`ifdef BOOTH_DONE_EN
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
`ifdef BOOTH_DONE_EN
  assign bus.done = done_q;
  assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_booth_mult_core.sv
// Scoreboard bench for booth_mult_core: stimulus queues expected results with due cycles, monitor checks.
module tb_booth_mult_core;

  localparam int N  = 5;
  localparam int RW = 8;

  logic clk;
  logic n_rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [7:0] val;
    int         due;
    bit         op;
  } exp_t;

  exp_t sq[$];

  booth_mult_core_if #(.N(N), .RW(RW)) bif ();

  booth_mult_core #(.N(N), .RW(RW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [7:0] ref_prod(input logic [4:0] m, input logic [4:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[7:0];
  endfunction

  // Monitor: result must equal the most recent expected completion, every cycle.
  logic [7:0] last;
  bit         armed;
  bit         done_exp;
  bit         busy_exp;
  initial begin
    armed = 0;
    last  = '0;
  end

  always @(negedge clk) begin
    exp_t e;
    done_exp = 0;
    if (sq.size() > 0 && sq[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_due cycle=%0d got=none want=due@%0d", cyc, sq[0].due);
      void'(sq.pop_front());
    end
    if (sq.size() > 0 && sq[0].due == cyc) begin
      e        = sq.pop_front();
      last     = e.val;
      armed    = 1;
      done_exp = e.op;
    end
    busy_exp = (sq.size() > 0) && sq[0].op && (cyc >= sq[0].due - N);
    if (armed) begin
      check("result", int'(bif.result), int'(last));
`ifdef BOOTH_DONE_EN
      check("done", int'(bif.done), int'(done_exp));
      check("busy", int'(bif.busy), int'(busy_exp));
`endif
    end
  end

  // Called #1 after a posedge with the DUT known to be IDLE at the next edge.
  task automatic issue(input logic [4:0] m, input logic [4:0] q);
    exp_t e;
    bif.start = 1'b1;
    bif.M     = m;
    bif.Q     = q;
    e.val = ref_prod(m, q);
    e.due = cyc + 1 + N;
    e.op  = 1;
    sq.push_back(e);
    for (int i = 0; i < N; i++) begin
      @(posedge clk) #1;
      bif.start = 1'($urandom_range(0, 1));
      bif.M     = 5'($urandom);
      bif.Q     = 5'($urandom);
    end
    @(posedge clk) #1;
    bif.start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk) #1;
  endtask

  initial begin
    exp_t e;
    total     = 0;
    bad       = 0;
    n_rst     = 1'b0;
    bif.start = 1'b0;
    bif.M     = '0;
    bif.Q     = '0;
    e.val = 8'h00; e.due = 1; e.op = 0;
    sq.push_back(e);
    @(posedge clk) #1;
    n_rst = 1'b1;

    issue(5'b00011, 5'b11100);
    idle(2);
    issue(5'd7, 5'd7);
    issue(5'b11011, 5'd6);
    idle(1);
    issue(5'b10000, 5'b10000);
    issue(5'b10000, 5'd1);
    idle(1);

    // Abort: reset lands on the third iteration edge.
    bif.start = 1'b1;
    bif.M     = 5'd9;
    bif.Q     = 5'd11;
    e.val = ref_prod(5'd9, 5'd11); e.due = cyc + 1 + N; e.op = 1;
    sq.push_back(e);
    @(posedge clk) #1;
    bif.start = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    n_rst = 1'b0;
    sq.delete();
    e.val = 8'h00; e.due = cyc + 1; e.op = 0;
    sq.push_back(e);
    @(posedge clk) #1;
    n_rst = 1'b1;

    issue(5'b00011, 5'b11100);
    for (int k = 0; k < 40; k++) begin
      issue(5'($urandom), 5'($urandom));
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 200 && sq.size() > 0; i++) @(posedge clk);
    if (sq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d_pending want=0_pending", sq.size());
    end
    @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
